// File: rtl/divider_pkg.sv
// Shared definitions for the iterative shift-subtract divider: controller
// state encoding and the default operand width.
package divider_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step_counter.sv
// Per-operation step counter for the divider: counts completed steps and
// flags the final one, wrapping to zero when that final step is taken.
module div_step_counter
  import divider_pkg::*;
#(
  parameter  int WIDTH = DIV_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] step,
  output logic          last
);

  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] r_step;
  logic          w_last;

  assign w_last = (r_step == LAST_VAL);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
    end else if (clear) begin
      r_step <= '0;
    end else if (inc) begin
      // Explicit wrap keeps non-power-of-two widths at exactly WIDTH steps.
      r_step <= w_last ? '0 : r_step + CW'(1);
    end
  end

  assign step = r_step;
  assign last = w_last;

endmodule

// File: rtl/quotient_shift_unit.sv
// Quotient register for the shift-subtract divider: loads the dividend,
// shifts in ~a_sign once per step and hands the result over with valid/ready.
module quotient_shift_unit
  import divider_pkg::*;
#(
  parameter  int WIDTH = DIV_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic             shift_en,
  input  logic             a_sign,
  input  logic             abort,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q_out,
  output logic             q_msb,
  output logic [CW-1:0]    step,
  output logic             busy,
  output logic             last_step,
  output logic             out_valid
);

  div_state_e       r_state;
  div_state_e       w_next_state;
  logic [WIDTH-1:0] r_q;
  logic             w_load_ok;
  logic             w_shift_ok;
  logic             w_clear;
  logic             w_last;
  logic [CW-1:0]    w_step;

  assign w_load_ok  = !abort && (r_state == IDLE) && load;
  assign w_shift_ok = !abort && (r_state == RUN) && shift_en;
  assign w_clear    = abort || w_load_ok;

  div_step_counter #(.WIDTH(WIDTH)) u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .inc   (w_shift_ok),
    .step  (w_step),
    .last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (load) w_next_state = RUN;
        RUN:     if (shift_en && w_last) w_next_state = DONE;
        DONE:    if (out_ready) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // The handshake leaves r_q untouched so the quotient stays readable in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (abort) begin
      r_q <= '0;
    end else if (w_load_ok) begin
      r_q <= dividend;
    end else if (w_shift_ok) begin
      r_q <= {r_q[WIDTH-2:0], ~a_sign};
    end
  end

  assign q_out     = r_q;
  assign q_msb     = r_q[WIDTH-1];
  assign step      = w_step;
  assign busy      = (r_state == RUN);
  assign last_step = (r_state == RUN) && w_last;
  assign out_valid = (r_state == DONE);

endmodule

// File: tb/tb_quotient_shift_unit.sv
// Self-checking bench for quotient_shift_unit (WIDTH=16): directed vector
// table, hand-written corner sequences and a randomized model comparison.
module tb_quotient_shift_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [W-1:0]  dividend;
  logic          shift_en;
  logic          a_sign;
  logic          abort;
  logic          out_ready;
  logic [W-1:0]  q_out;
  logic          q_msb;
  logic [3:0]    step;
  logic          busy;
  logic          last_step;
  logic          out_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: operation phase (0 idle, 1 running, 2 result waiting),
  // register contents and the number of steps taken so far.
  int          m_phase;
  logic [15:0] m_q;
  int          m_step;

  typedef struct {
    logic        ld;
    logic [15:0] div;
    logic        sh;
    logic        a;
    logic        ab;
    logic        rdy;
    logic [15:0] eq;
    int          est;
    logic        ebusy;
    logic        evalid;
    logic        emsb;
  } vec_t;

  vec_t vecs [9];

  quotient_shift_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .dividend  (dividend),
    .shift_en  (shift_en),
    .a_sign    (a_sign),
    .abort     (abort),
    .out_ready (out_ready),
    .q_out     (q_out),
    .q_msb     (q_msb),
    .step      (step),
    .busy      (busy),
    .last_step (last_step),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_q     = '0;
    m_step  = 0;
  endtask

  // Apply the current inputs to the model, then advance the DUT one edge.
  task automatic cycle();
    if (abort) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (load) begin
             m_q     = dividend;
             m_step  = 0;
             m_phase = 1;
           end
        1: if (shift_en) begin
             m_q = {m_q[14:0], !a_sign};
             if (m_step == W - 1) begin
               m_step  = 0;
               m_phase = 2;
             end else begin
               m_step = m_step + 1;
             end
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q_out"},     q_out,     m_q);
    check({tag, ".q_msb"},     q_msb,     m_q[15]);
    check({tag, ".step"},      step,      m_step);
    check({tag, ".busy"},      busy,      m_phase == 1);
    check({tag, ".last_step"}, last_step, (m_phase == 1) && (m_step == W - 1));
    check({tag, ".out_valid"}, out_valid, m_phase == 2);
  endtask

  task automatic idle_inputs();
    load      = 1'b0;
    dividend  = '0;
    shift_en  = 1'b0;
    a_sign    = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int shifts;
    int cycles;

    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Directed table: inputs before the edge, expected state after it.
    vecs[0] = '{1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8001, 0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 2, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0006, 2, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0006, 2, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      load      = vecs[i].ld;
      dividend  = vecs[i].div;
      shift_en  = vecs[i].sh;
      a_sign    = vecs[i].a;
      abort     = vecs[i].ab;
      out_ready = vecs[i].rdy;
      cycle();
      check($sformatf("vec%0d.q_out", i),     q_out,     vecs[i].eq);
      check($sformatf("vec%0d.step", i),      step,      vecs[i].est);
      check($sformatf("vec%0d.busy", i),      busy,      vecs[i].ebusy);
      check($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].evalid);
      check($sformatf("vec%0d.q_msb", i),     q_msb,     vecs[i].emsb);
    end
    idle_inputs();

    // Async reset five steps into an operation, then a clean restart.
    load = 1'b1; dividend = 16'h5A5A;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      shift_en = 1'b1;
      a_sign   = 1'($urandom_range(0, 1));
      cycle();
    end
    shift_en = 1'b0;
    check("pre_rst.step", step, 5);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst.q_out",     q_out,     16'h0000);
    check("async_rst.step",      step,      0);
    check("async_rst.busy",      busy,      1'b0);
    check("async_rst.out_valid", out_valid, 1'b0);
    #2 rst = 1'b0;
    load = 1'b1; dividend = 16'h1234;
    cycle();
    load = 1'b0;
    check("post_rst_load.q_out", q_out, 16'h1234);
    check("post_rst_load.busy",  busy,  1'b1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;

    // Full divide: a_sign 0,1,0,1,... shifts in 1,0,1,0,... giving 0xAAAA.
    load = 1'b1; dividend = 16'h0000;
    cycle();
    load = 1'b0;
    for (int i = 0; i < W; i++) begin
      shift_en = 1'b1;
      a_sign   = 1'(i % 2);
      if (i == W - 2) check("full.last_step_early", last_step, 1'b0);
      if (i == W - 1) check("full.last_step_16th",  last_step, 1'b1);
      cycle();
    end
    shift_en = 1'b0;
    check("full.q_out",     q_out,     16'hAAAA);
    check("full.out_valid", out_valid, 1'b1);
    check_all("full");

    // Consumer holds off for 10 cycles; load and shift_en must be ignored.
    for (int i = 0; i < 10; i++) begin
      load     = 1'(i == 3);
      dividend = 16'h1111;
      shift_en = 1'(i == 5);
      cycle();
      check($sformatf("hold%0d.out_valid", i), out_valid, 1'b1);
      check($sformatf("hold%0d.q_out", i),     q_out,     16'hAAAA);
    end
    idle_inputs();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("handshake.out_valid", out_valid, 1'b0);
    check("handshake.busy",      busy,      1'b0);
    check("handshake.q_out",     q_out,     16'hAAAA);
    load = 1'b1; dividend = 16'h00FF;
    cycle();
    load = 1'b0;
    check("b2b_load.busy",  busy,  1'b1);
    check("b2b_load.q_out", q_out, 16'h00FF);
    abort = 1'b1;
    cycle();
    abort = 1'b0;

    // Randomly stalled run with a stray load; result must still be 0xAAAA.
    load = 1'b1; dividend = 16'h0000;
    cycle();
    load   = 1'b0;
    shifts = 0;
    cycles = 0;
    while (shifts < W && cycles < 200) begin
      shift_en = 1'($urandom_range(0, 2) == 0);
      a_sign   = 1'(shifts % 2);
      load     = 1'($urandom_range(0, 7) == 0);
      dividend = 16'($urandom);
      if (shift_en) shifts++;
      cycle();
      check_all("stall");
      cycles++;
    end
    idle_inputs();
    check("stall.completed",  shifts,    W);
    check("stall.q_out",      q_out,     16'hAAAA);
    check("stall.out_valid",  out_valid, 1'b1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // shift_en in IDLE must leave q alone.
    shift_en = 1'b1; a_sign = 1'b0;
    cycle();
    shift_en = 1'b0;
    check("idle_shift.q_out", q_out, 16'hAAAA);

    // Abort beats shift_en, load and out_ready in the same cycle.
    load = 1'b1; dividend = 16'hFFFF;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      shift_en = 1'b1; a_sign = 1'b0;
      cycle();
    end
    check("abort_pre.step", step, 7);
    abort = 1'b1; shift_en = 1'b1; load = 1'b1; out_ready = 1'b1;
    cycle();
    idle_inputs();
    check("abort.q_out",     q_out,     16'h0000);
    check("abort.step",      step,      0);
    check("abort.busy",      busy,      1'b0);
    check("abort.out_valid", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("abort_after%0d.out_valid", i), out_valid, 1'b0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      load      = 1'($urandom_range(0, 3) == 0);
      dividend  = 16'($urandom);
      shift_en  = 1'($urandom_range(0, 1));
      a_sign    = 1'($urandom_range(0, 1));
      abort     = 1'($urandom_range(0, 31) == 0);
      out_ready = 1'($urandom_range(0, 2) == 0);
      cycle();
      check_all("rand");
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/quotient_shift_unit.md
# quotient_shift_unit

Parametrised quotient register for the iterative shift-subtract divider. It is the successor to the fixed 16-bit quotient shifter and adds a configurable width, dividend load, a per-operation step counter, a done/valid handshake toward the consumer, and synchronous abort. It sits beside the remainder (A) register: each step shifts the quotient left, exposes the outgoing MSB for the A register's LSB, and shifts in the inverted sign of the new partial remainder.

## Interface
Parameters:
- WIDTH, 16, quotient/dividend width in bits; legal values are 2 and up.
- CW, $clog2(WIDTH), step counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  start operation; captures dividend (honoured in IDLE only).
- dividend  in  WIDTH  initial quotient-register contents.
- shift_en  in  1  perform one division step (honoured in RUN only).
- a_sign  in  1  sign bit of the partial remainder after this step's subtract; the shifted-in bit is ~a_sign.
- abort  in  1  synchronous cancel, valid in any state.
- out_ready  in  1  consumer accepts the result.
- q_out  out  WIDTH  register contents.
- q_msb  out  1  q_out[WIDTH-1], combinational; the bit leaving on the next shift.
- step  out  CW  number of steps completed in the current operation.
- busy  out  1  high in RUN.
- last_step  out  1  high in RUN when step == WIDTH-1.
- out_valid  out  1  high in DONE.

## Operation
States are IDLE, RUN and DONE.
- IDLE:
  - load=1: q <= dividend, step <= 0, go to RUN.
  - shift_en is ignored.
- RUN:
  - shift_en=1: q <= {q[WIDTH-2:0], ~a_sign}, step <= step+1.
  - If last_step and shift_en, go to DONE. step wraps to 0 on this edge.
  - load is ignored.
  - shift_en=0 holds all state; stalls of any length are legal.
- DONE:
  - q holds the final quotient.
  - out_valid and out_ready together: go to IDLE with q unchanged, so q_out stays readable.
  - load and shift_en are ignored until the return to IDLE.
- Abort:
  - abort=1 in any state: next state IDLE, q <= 0, step <= 0.
  - Abort has priority over load, shift_en and out_ready in the same cycle.
- Reset values: state IDLE, q_out 0, q_msb 0, step 0, busy 0, last_step 0, out_valid 0.
- Width rules:
  - Exactly WIDTH steps per operation.
  - step never exceeds WIDTH-1 while observable in RUN.
  - No sign handling; operands are unsigned.

## Timing
- All state updates occur on the rising clk edge.
- busy, last_step and out_valid are decoded from registered state, with no input-to-output combinational path.
- q_msb is combinational from q only.
- Load latency: load at edge n gives busy=1 and q_out=dividend after edge n.
- Completion: the WIDTH-th shift_en at edge n gives out_valid=1 after edge n. The minimum load-to-valid time is WIDTH+1 edges.
- Handshake: out_valid stays high until the edge where out_ready=1. out_valid drops after that edge.
- Back-to-back operations: load is first honoured on the cycle after the handshake, because IDLE is a separate state.
- Asynchronous rst mid-operation forces the reset values immediately. Behaviour after release is as from power-up.

## Structure
- Package divider_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default DIV_WIDTH=16 constant, shared with the remainder register and the controller.
- Sub-module div_step_counter, parametrised by WIDTH. It provides:
  - ports: clear, inc, step, last (last = step==WIDTH-1);
  - wrap-to-0 on inc when last is set.
- The unit instantiates the counter and holds the FSM and the shift register.

## Test plan
All scenarios use WIDTH=16.
- Reset: assert rst mid-RUN after 5 steps -> q_out=0x0000, step=0, busy=0, out_valid=0 immediately; a later load of 0x1234 starts cleanly.
- Single step: load 0x8001, then shift_en with a_sign=0 -> before the edge q_msb=1; after it q_out=0x0003 and step=1.
- Full divide: load 0x0000, then 16 shift_en pulses with a_sign alternating 0,1,0,1,… -> q_out=0xAAAA, last_step high during the 16th step, out_valid=1 on the next cycle.
- Stalls and ignored inputs:
  - Random shift_en gaps give the same 0xAAAA result.
  - A load pulse mid-RUN leaves q unchanged.
  - shift_en in IDLE leaves q unchanged.
- Handshake:
  - Hold out_ready=0 for 10 cycles -> out_valid stays high and q stays 0xAAAA.
  - Raise out_ready -> IDLE next cycle with q_out still 0xAAAA.
  - load on that next cycle is accepted.
- Abort priority: load 0xFFFF, run 7 steps, then assert abort together with shift_en -> q_out=0x0000, step=0, state IDLE, no out_valid pulse.
